// File: rtl/conv_window_stream.sv
// Streaming KxK sliding-window generator: a (K-1)*IFM_SIZE+K pixel shift line
// feeding a registered flat window with valid/ready flow control and stride gating.
module conv_window_stream #(
  parameter int DATA_WIDTH  = 32,
  parameter int IFM_SIZE    = 28,
  parameter int KERNEL_SIZE = 5,
  parameter int STRIDE      = 1
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              flush,
  input  logic                                              in_valid,
  output logic                                              in_ready,
  input  logic [DATA_WIDTH-1:0]                             in_data,
  output logic                                              out_valid,
  input  logic                                              out_ready,
  output logic [KERNEL_SIZE*KERNEL_SIZE*DATA_WIDTH-1:0]     out_window,
  output logic [$clog2(IFM_SIZE)-1:0]                       out_row,
  output logic [$clog2(IFM_SIZE)-1:0]                       out_col,
  output logic                                              frame_done
);

  localparam int K     = KERNEL_SIZE;
  localparam int DW    = DATA_WIDTH;
  localparam int CW    = $clog2(IFM_SIZE);
  localparam int WW    = K * K * DW;
  localparam int BUF_D = (K > 1) ? ((K - 1) * IFM_SIZE + K - 1) : 1;
  localparam int PHW   = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  localparam logic [CW-1:0]  LAST_POS = CW'(IFM_SIZE - 1);
  localparam logic [CW-1:0]  K_M1     = CW'(K - 1);
  localparam logic [PHW-1:0] PH_LAST  = PHW'(STRIDE - 1);

  // The newest pixel lives on in_data; buf_q holds the older ones, slot 0 newest.
  logic [DW-1:0]  buf_q [BUF_D];
  logic [DW-1:0]  buf_d [BUF_D];
  logic [CW-1:0]  pr_q, pr_d, pc_q, pc_d;
  logic [PHW-1:0] rph_q, rph_d, cph_q, cph_d;
  logic [CW-1:0]  orow_q, orow_d, ocol_q, ocol_d;
  logic           out_valid_q, out_valid_d;
  logic [WW-1:0]  out_window_q, out_window_d;
  logic [CW-1:0]  out_row_q, out_row_d, out_col_q, out_col_d;
  logic           frame_done_q, frame_done_d;
  logic [WW-1:0]  win_taps;

  logic acc, take, row_ok, col_ok, fire, last_col, last_pix;

  // Handshake: a pixel transfers when in_valid & in_ready; a window transfers
  // when out_valid & out_ready; in_ready stays high unless a window is held.
  assign in_ready = !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign take     = acc && !flush;
  assign row_ok   = (pr_q >= K_M1) && (rph_q == '0);
  assign col_ok   = (pc_q >= K_M1) && (cph_q == '0);
  assign fire     = take && row_ok && col_ok;
  assign last_col = (pc_q == LAST_POS);
  assign last_pix = last_col && (pr_q == LAST_POS);

  for (genvar e = 0; e < K * K; e++) begin : g_tap
    localparam int R   = e / K;
    localparam int C   = e % K;
    localparam int IDX = (K - 1 - R) * IFM_SIZE + (K - 1 - C);
    if (IDX == 0) begin : g_new
      assign win_taps[e*DW +: DW] = in_data;
    end else begin : g_old
      assign win_taps[e*DW +: DW] = buf_q[IDX-1];
    end
  end

  always_comb begin
    for (int i = 0; i < BUF_D; i++) buf_d[i] = buf_q[i];
    pr_d         = pr_q;
    pc_d         = pc_q;
    rph_d        = rph_q;
    cph_d        = cph_q;
    orow_d       = orow_q;
    ocol_d       = ocol_q;
    out_window_d = out_window_q;
    out_row_d    = out_row_q;
    out_col_d    = out_col_q;
    frame_done_d = take && last_pix;

    if (take) begin
      buf_d[0] = in_data;
      for (int i = 1; i < BUF_D; i++) buf_d[i] = buf_q[i-1];
    end

    if (flush) begin
      pr_d   = '0;
      pc_d   = '0;
      rph_d  = '0;
      cph_d  = '0;
      orow_d = '0;
      ocol_d = '0;
    end else if (take) begin
      if (last_col) begin
        pc_d   = '0;
        cph_d  = '0;
        ocol_d = '0;
        if (last_pix) begin
          pr_d   = '0;
          rph_d  = '0;
          orow_d = '0;
        end else begin
          pr_d = pr_q + CW'(1);
          if (pr_q >= K_M1) begin
            rph_d = (rph_q == PH_LAST) ? '0 : rph_q + PHW'(1);
            if (rph_q == PH_LAST) orow_d = orow_q + CW'(1);
          end
        end
      end else begin
        pc_d = pc_q + CW'(1);
        if (pc_q >= K_M1) begin
          cph_d = (cph_q == PH_LAST) ? '0 : cph_q + PHW'(1);
          if (cph_q == PH_LAST) ocol_d = ocol_q + CW'(1);
        end
      end
    end

    if (flush)          out_valid_d = 1'b0;
    else if (fire)      out_valid_d = 1'b1;
    else if (out_ready) out_valid_d = 1'b0;
    else                out_valid_d = out_valid_q;

    if (fire) begin
      out_window_d = win_taps;
      out_row_d    = orow_q;
      out_col_d    = ocol_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BUF_D; i++) buf_q[i] <= '0;
      pr_q         <= '0;
      pc_q         <= '0;
      rph_q        <= '0;
      cph_q        <= '0;
      orow_q       <= '0;
      ocol_q       <= '0;
      out_valid_q  <= 1'b0;
      out_window_q <= '0;
      out_row_q    <= '0;
      out_col_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      pr_q         <= pr_d;
      pc_q         <= pc_d;
      rph_q        <= rph_d;
      cph_q        <= cph_d;
      orow_q       <= orow_d;
      ocol_q       <= ocol_d;
      out_valid_q  <= out_valid_d;
      out_window_q <= out_window_d;
      out_row_q    <= out_row_d;
      out_col_q    <= out_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_window = out_window_q;
  assign out_row    = out_row_q;
  assign out_col    = out_col_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_stream.sv
// Bench for conv_window_stream: a 28x28/K5/S1 instance and an 8x8/K3/S2 instance,
// driven with pixel-index frames and checked against closed-form window contents.
module tb_conv_window_stream;

  localparam int DW    = 32;
  localparam int IFM_A = 28;
  localparam int K_A   = 5;
  localparam int IFM_B = 8;
  localparam int K_B   = 3;
  localparam int S_B   = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic                    flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, frame_done_a;
  logic [DW-1:0]           in_data_a;
  logic [K_A*K_A*DW-1:0]   out_window_a;
  logic [4:0]              out_row_a, out_col_a;

  logic                    flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, frame_done_b;
  logic [DW-1:0]           in_data_b;
  logic [K_B*K_B*DW-1:0]   out_window_b;
  logic [2:0]              out_row_b, out_col_b;

  conv_window_stream #(.DATA_WIDTH(DW), .IFM_SIZE(IFM_A), .KERNEL_SIZE(K_A), .STRIDE(1)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_window(out_window_a), .out_row(out_row_a), .out_col(out_col_a), .frame_done(frame_done_a)
  );

  conv_window_stream #(.DATA_WIDTH(DW), .IFM_SIZE(IFM_B), .KERNEL_SIZE(K_B), .STRIDE(S_B)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_window(out_window_b), .out_row(out_row_b), .out_col(out_col_b), .frame_done(frame_done_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard for dut_a: expected elem0 and {row,col} per window, in order.
  logic [31:0] exp_q[$];
  logic [9:0]  exp_rc_q[$];
  int          rx_a = 0;
  int          rx_b = 0;
  int          hold_cnt = 0;
  int          mark_last = -1;
  int          mark_first = -1;
  logic [31:0] m_last_e24, m_first_e0, m_first_e24;
  logic [4:0]  m_last_row, m_last_col;
  logic        held_a = 1'b0;
  logic [K_A*K_A*DW-1:0] held_win;
  logic [4:0]  held_row, held_col;

  // Output-ready pattern: always ready, or ready one cycle in three.
  logic toggle_en = 1'b0;
  int   tog_cnt = 0;
  initial out_ready_a = 1'b1;
  always @(posedge clk) begin
    #1;
    tog_cnt++;
    out_ready_a = toggle_en ? (tog_cnt % 3 == 0) : 1'b1;
  end

  always @(negedge clk) begin
    if (reset || !out_valid_a) begin
      held_a = 1'b0;
    end else begin
      if (held_a)
        check("hold_stable", (out_window_a == held_win) && (out_row_a == held_row) &&
              (out_col_a == held_col), 1);
      if (!out_ready_a) begin
        check("hold_in_ready", in_ready_a, 0);
        held_a   = 1'b1;
        held_win = out_window_a;
        held_row = out_row_a;
        held_col = out_col_a;
        hold_cnt++;
      end else begin
        held_a = 1'b0;
        if (exp_q.size() == 0) begin
          check("unexpected_window_a", 1, 0);
        end else begin
          logic [31:0] e0;
          logic [9:0]  rc;
          e0 = exp_q.pop_front();
          rc = exp_rc_q.pop_front();
          for (int r = 0; r < K_A; r++)
            for (int c = 0; c < K_A; c++)
              check("win_elem_a", out_window_a[(r*K_A+c)*DW +: DW], e0 + r*IFM_A + c);
          check("win_row_a", out_row_a, rc[9:5]);
          check("win_col_a", out_col_a, rc[4:0]);
          if (rx_a == mark_last) begin
            m_last_e24 = out_window_a[24*DW +: DW];
            m_last_row = out_row_a;
            m_last_col = out_col_a;
          end
          if (rx_a == mark_first) begin
            m_first_e0  = out_window_a[0 +: DW];
            m_first_e24 = out_window_a[24*DW +: DW];
          end
          rx_a++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b && out_ready_b) begin
      if (rx_b >= 9) begin
        check("unexpected_window_b", 1, 0);
      end else begin
        int i, j;
        i = rx_b / 3;
        j = rx_b % 3;
        check("win_row_b", out_row_b, i);
        check("win_col_b", out_col_b, j);
        for (int r = 0; r < K_B; r++)
          for (int c = 0; c < K_B; c++)
            check("win_elem_b", out_window_b[(r*K_B+c)*DW +: DW], (S_B*i+r)*IFM_B + S_B*j + c);
      end
      rx_b++;
    end
  end

  task automatic drive_pix_a(input logic [31:0] val, input bit gaps);
    bit ok;
    int wait_cyc;
    if (gaps && $urandom_range(0, 3) == 0) begin
      in_valid_a = 1'b0;
      @(posedge clk); #1;
    end
    in_valid_a = 1'b1;
    in_data_a  = val;
    ok = 1'b0;
    wait_cyc = 0;
    while (!ok && wait_cyc < 1000) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk); #1;
      wait_cyc++;
    end
    in_valid_a = 1'b0;
    if (!ok) check("accept_timeout_a", 0, 1);
  endtask

  task automatic send_frame_a(input logic [31:0] base, input int npix, input bit gaps,
                              input bit check_first);
    for (int p = 0; p < npix; p++) begin
      int pr, pc;
      pr = p / IFM_A;
      pc = p % IFM_A;
      if (pr >= K_A-1 && pc >= K_A-1) begin
        exp_q.push_back(base + (pr-(K_A-1))*IFM_A + (pc-(K_A-1)));
        exp_rc_q.push_back({5'(pr-(K_A-1)), 5'(pc-(K_A-1))});
      end
      drive_pix_a(base + p, gaps);
      check("frame_done_a", frame_done_a, (p == IFM_A*IFM_A-1));
      if (check_first && (p == 115 || p == 116))
        check("first_valid_a", out_valid_a, (p == 116));
    end
  endtask

  task automatic drain;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state;
    check("rst_out_valid_a", out_valid_a, 0);
    check("rst_frame_done_a", frame_done_a, 0);
    check("rst_in_ready_a", in_ready_a, 1);
    check("rst_out_row_a", out_row_a, 0);
    check("rst_out_col_a", out_col_a, 0);
    check("rst_out_window_a", (out_window_a == '0), 1);
    check("rst_out_valid_b", out_valid_b, 0);
    check("rst_in_ready_b", in_ready_b, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rx0;
    reset = 1'b1;
    flush_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    flush_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0; out_ready_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    @(posedge clk); #1;

    // Frames 0 and 1000 back-to-back, always ready.
    rx0 = rx_a;
    mark_last  = rx0 + 575;
    mark_first = rx0 + 576;
    send_frame_a(0, 784, 0, 1);
    send_frame_a(1000, 784, 0, 1);
    drain();
    check("t1_t4_count", rx_a - rx0, 1152);
    check("t1_last_e24", m_last_e24, 783);
    check("t1_last_row", m_last_row, 23);
    check("t1_last_col", m_last_col, 23);
    check("t4_first_e0", m_first_e0, 1000);
    check("t4_first_e24", m_first_e24, 1116);
    check("t1_queue_empty", exp_q.size(), 0);

    // Back-pressure: consumer ready one cycle in three.
    toggle_en = 1'b1;
    rx0 = rx_a;
    send_frame_a(2000, 784, 0, 0);
    drain();
    toggle_en = 1'b0;
    drain();
    check("t2_count", rx_a - rx0, 576);
    check("t2_hold_seen", (hold_cnt > 0), 1);
    check("t2_queue_empty", exp_q.size(), 0);

    // Reset mid-frame after pixel 300, then a fresh frame.
    send_frame_a(3000, 301, 0, 0);
    drain();
    check("t5_queue_empty", exp_q.size(), 0);
    reset = 1'b1;
    #1;
    check_reset_state();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    reset = 1'b0;
    @(posedge clk); #1;
    rx0 = rx_a;
    mark_last = rx0 + 575;
    send_frame_a(0, 784, 0, 1);
    drain();
    check("t5_count", rx_a - rx0, 576);
    check("t5_last_e24", m_last_e24, 783);
    check("t5_last_row", m_last_row, 23);

    // Random input gaps, flush in place of pixel 50, then a full frame.
    send_frame_a(4000, 50, 1, 0);
    flush_a    = 1'b1;
    in_valid_a = 1'b1;
    in_data_a  = 4050;
    @(posedge clk); #1;
    flush_a    = 1'b0;
    in_valid_a = 1'b0;
    check("t6_flush_out_valid", out_valid_a, 0);
    check("t6_flush_frame_done", frame_done_a, 0);
    rx0 = rx_a;
    send_frame_a(5000, 784, 1, 1);
    drain();
    check("t6_count", rx_a - rx0, 576);
    check("t6_queue_empty", exp_q.size(), 0);

    // K=3, IFM=8, stride 2 on the second instance.
    for (int p = 0; p < IFM_B*IFM_B; p++) begin
      in_valid_b = 1'b1;
      in_data_b  = p;
      @(negedge clk);
      check("b_in_ready", in_ready_b, 1);
      @(posedge clk); #1;
      check("b_frame_done", frame_done_b, (p == IFM_B*IFM_B-1));
    end
    in_valid_b = 1'b0;
    drain();
    check("t3_count", rx_b, 9);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
